// File: rtl/if_fetch_unit.sv
// Instruction fetch requester: owns the PC, drives a 1-cycle-latency memory port and delivers
// {pc, instr, valid} through a 1-entry skid buffer with redirect kill and end-of-memory fault.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_read_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misaligned,
  output logic        fetch_fault
);

  localparam logic [31:0] LastPc = 32'(MEM_BYTES - 4);

  logic [31:0] r_fetch_pc, w_fetch_pc;
  logic        r_pend_valid, w_pend_valid;
  logic [31:0] r_pend_pc, w_pend_pc;
  logic        r_skid_valid, w_skid_valid;
  logic [31:0] r_skid_pc, w_skid_pc;
  logic [31:0] r_skid_instr, w_skid_instr;
  logic        r_if_valid, w_if_valid;
  logic [31:0] r_if_pc, w_if_pc;
  logic [31:0] r_if_instr, w_if_instr;
  logic        r_misaligned, w_misaligned;
  logic        r_fetch_fault, w_fetch_fault;

  logic w_issue_ok;
  logic w_in_range;
  logic w_issue;

  // Issue is gated by a full skid, which guarantees at most one response in flight.
  assign w_issue_ok = !redirect_valid && !stall && !r_skid_valid && !r_fetch_fault;
  assign w_in_range = (r_fetch_pc <= LastPc);
  assign w_issue    = w_issue_ok && w_in_range;

  always_comb begin
    w_fetch_pc    = r_fetch_pc;
    w_pend_valid  = w_issue;
    w_pend_pc     = r_pend_pc;
    w_skid_valid  = r_skid_valid;
    w_skid_pc     = r_skid_pc;
    w_skid_instr  = r_skid_instr;
    w_if_valid    = r_if_valid;
    w_if_pc       = r_if_pc;
    w_if_instr    = r_if_instr;
    w_misaligned  = 1'b0;
    w_fetch_fault = r_fetch_fault;

    if (w_issue) begin
      w_pend_pc  = r_fetch_pc;
      w_fetch_pc = r_fetch_pc + 32'd4;
    end
    if (w_issue_ok && !w_in_range) begin
      w_fetch_fault = 1'b1;
    end

    if (redirect_valid) begin
      w_if_valid    = 1'b0;
      w_skid_valid  = 1'b0;
      w_pend_valid  = 1'b0;
      w_fetch_pc    = {redirect_target[31:2], 2'b00};
      w_fetch_fault = 1'b0;
      w_misaligned  = |redirect_target[1:0];
    end else if (!r_if_valid || !stall) begin
      if (r_skid_valid) begin
        w_if_valid   = 1'b1;
        w_if_pc      = r_skid_pc;
        w_if_instr   = r_skid_instr;
        w_skid_valid = 1'b0;
      end else if (r_pend_valid) begin
        w_if_valid = 1'b1;
        w_if_pc    = r_pend_pc;
        w_if_instr = imem_read_instr;
      end else begin
        w_if_valid = 1'b0;
      end
    end else if (r_pend_valid) begin
      w_skid_valid = 1'b1;
      w_skid_pc    = r_pend_pc;
      w_skid_instr = imem_read_instr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_pc     <= 32'd0;
      r_skid_valid  <= 1'b0;
      r_skid_pc     <= 32'd0;
      r_skid_instr  <= 32'd0;
      r_if_valid    <= 1'b0;
      r_if_pc       <= 32'd0;
      r_if_instr    <= 32'd0;
      r_misaligned  <= 1'b0;
      r_fetch_fault <= 1'b0;
    end else begin
      r_fetch_pc    <= w_fetch_pc;
      r_pend_valid  <= w_pend_valid;
      r_pend_pc     <= w_pend_pc;
      r_skid_valid  <= w_skid_valid;
      r_skid_pc     <= w_skid_pc;
      r_skid_instr  <= w_skid_instr;
      r_if_valid    <= w_if_valid;
      r_if_pc       <= w_if_pc;
      r_if_instr    <= w_if_instr;
      r_misaligned  <= w_misaligned;
      r_fetch_fault <= w_fetch_fault;
    end
  end

  assign imem_address = r_fetch_pc;
  assign if_valid     = r_if_valid;
  assign if_pc        = r_if_pc;
  assign if_instr     = r_if_instr;
  assign misaligned   = r_misaligned;
  assign fetch_fault  = r_fetch_fault;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: startup, stall/skid, redirect, redirect+stall, end-of-memory
// fault and asynchronous reset mid-stall, against a registered-read memory model.
module tb_if_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_read_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misaligned;
  logic        fetch_fault;

  logic [31:0] mem [0:31];
  int checks = 0;
  int errors = 0;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(128)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_address   (imem_address),
    .imem_read_instr(imem_read_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misaligned     (misaligned),
    .fetch_fault    (fetch_fault)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) imem_read_instr <= mem[imem_address[6:2]];

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    case (pc)
      32'h00:  exp_instr = 32'h0140_0193;
      32'h04:  exp_instr = 32'h0781_A403;
      32'h08:  exp_instr = 32'h0034_0533;
      32'h1C:  exp_instr = 32'h0034_76B3;
      default: exp_instr = 32'hC0DE_0000 | pc;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_instr"}, if_instr, exp_instr(pc));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_pc"}, if_pc, 32'd0);
    chk({tag, "_instr"}, if_instr, 32'd0);
    chk({tag, "_mis"}, {31'd0, misaligned}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
    chk({tag, "_addr"}, imem_address, 32'd0);
  endtask

  // Startup sequence after reset release: first delivery two cycles later, then 1/cycle.
  task automatic startup(input string tag);
    tick();
    chk({tag, "_c1_valid"}, {31'd0, if_valid}, 32'd0);
    tick();
    chk_out({tag, "_pc0"}, 32'h0);
    tick();
    chk_out({tag, "_pc4"}, 32'h4);
    tick();
    chk_out({tag, "_pc8"}, 32'h8);
  endtask

  initial begin
    logic [31:0] exp_pc;
    bit          done;
    int          guard;

    for (int i = 0; i < 32; i++) mem[i] = exp_instr(32'(i * 4));
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    tick();
    tick();
    chk_reset_state("reset");

    // Scenario 1: startup
    reset = 1'b0;
    startup("s1");

    // Scenario 2: stall three cycles while pc 0x8 is held; skid captures 0xC
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("s2_hold", 32'h8);
    end
    stall = 1'b0;
    tick();
    chk_out("s2_skid", 32'hC);
    tick();
    chk("s2_bubble", {31'd0, if_valid}, 32'd0);
    tick();
    chk_out("s2_after", 32'h10);

    // Scenario 3: redirect to 0x1C while 0x10 is delivered; 0x14/0x18 are killed
    redirect_valid  = 1'b1;
    redirect_target = 32'h1C;
    tick();
    redirect_valid = 1'b0;
    chk("s3_kill", {31'd0, if_valid}, 32'd0);
    chk("s3_mis", {31'd0, misaligned}, 32'd0);
    chk("s3_addr", imem_address, 32'h1C);
    tick();
    chk("s3_gap", {31'd0, if_valid}, 32'd0);
    tick();
    chk_out("s3_tgt", 32'h1C);

    // Scenario 4: fill skid under stall, then redirect to misaligned 0x1E with stall still high
    stall = 1'b1;
    tick();
    chk_out("s4_hold", 32'h1C);
    redirect_valid  = 1'b1;
    redirect_target = 32'h1E;
    tick();
    redirect_valid = 1'b0;
    chk("s4_clear", {31'd0, if_valid}, 32'd0);
    chk("s4_mis_on", {31'd0, misaligned}, 32'd1);
    chk("s4_addr", imem_address, 32'h1C);
    tick();
    chk("s4_mis_off", {31'd0, misaligned}, 32'd0);
    chk("s4_stalled", {31'd0, if_valid}, 32'd0);
    stall = 1'b0;
    tick();
    chk("s4_gap", {31'd0, if_valid}, 32'd0);
    tick();
    chk_out("s4_tgt", 32'h1C);

    // Scenario 5: free-run to end of memory, expect contiguous deliveries up to 0x7C
    exp_pc = 32'h20;
    done   = 1'b0;
    guard  = 0;
    while (!done && guard < 200) begin
      tick();
      guard++;
      if (if_valid) begin
        chk("s5_pc", if_pc, exp_pc);
        chk("s5_instr", if_instr, exp_instr(exp_pc));
        if (exp_pc == 32'h7C) done = 1'b1;
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL s5_timeout observed next_pc %h expected reach 0000007c", exp_pc);
    end
    chk("s5_fault_set", {31'd0, fetch_fault}, 32'd1);
    tick();
    chk("s5_drop", {31'd0, if_valid}, 32'd0);
    tick();
    tick();
    tick();
    chk("s5_idle", {31'd0, if_valid}, 32'd0);
    chk("s5_halt_addr", imem_address, 32'h80);
    chk("s5_fault_sticky", {31'd0, fetch_fault}, 32'd1);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0;
    tick();
    redirect_valid = 1'b0;
    chk("s5_fault_clr", {31'd0, fetch_fault}, 32'd0);
    chk("s5_re_addr", imem_address, 32'h0);
    tick();
    chk("s5_gap", {31'd0, if_valid}, 32'd0);
    tick();
    chk_out("s5_redeliver", 32'h0);

    // Scenario 6: async reset with output (0x4) and skid (0x8) both full under stall
    tick();
    chk_out("s6_pre", 32'h4);
    stall = 1'b1;
    tick();
    chk_out("s6_held", 32'h4);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("s6_async");
    tick();
    stall = 1'b0;
    reset = 1'b0;
    startup("s6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Requester side of the synchronous instruction-memory read port. It owns the PC and drives the word address. It accounts for the memory's 1-cycle registered read latency and delivers {pc, instr, valid} to the IF/ID register. It supports downstream stall through a 1-entry skid buffer, branch redirect with in-flight kill, and an end-of-memory fetch fault.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_BYTES, 128, byte size of instruction memory; highest legal fetch address is MEM_BYTES-4

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_address  out  32  byte address presented to instruction memory (= fetch_pc register)
imem_read_instr  in  32  memory data; valid in cycle n+1 for the address driven in cycle n
stall  in  1  IF/ID not ready; hold the current output
redirect_valid  in  1  branch/jump taken; load redirect_target
redirect_target  in  32  new fetch byte address
if_valid  out  1  if_pc/if_instr hold a live instruction
if_pc  out  32  PC of the delivered instruction
if_instr  out  32  delivered instruction word
misaligned  out  1  one-cycle pulse: redirect_target[1:0] != 0
fetch_fault  out  1  sticky: fetch_pc ran past MEM_BYTES-4

Behaviour:
- Reset (async, any time): fetch_pc=RESET_PC; pend_valid=0; skid_valid=0; if_valid=0; if_pc=0; if_instr=0; misaligned=0; fetch_fault=0. All in-flight data is discarded.
- Issue condition: !redirect_valid && !stall && !skid_valid && !fetch_fault && fetch_pc <= MEM_BYTES-4.
  - On issue: pend_valid<=1, pend_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (32-bit wrap, unreachable in practice).
  - Otherwise: pend_valid<=0 and fetch_pc holds.
- Fault: if the issue condition holds except that fetch_pc > MEM_BYTES-4, set fetch_fault=1. No issue occurs and fetch halts until redirect or reset.
- Response: when pend_valid=1, the current-cycle tuple is {pend_pc, imem_read_instr}. When pend_valid=0, imem_read_instr is ignored, including X contents.
- Output / skid update, evaluated in priority order:
  1. redirect_valid: if_valid<=0, skid_valid<=0, pend_valid<=0 (the in-flight response is killed), fetch_pc<={redirect_target[31:2],2'b00}, fetch_fault<=0, misaligned<=|redirect_target[1:0]. Redirect beats stall.
  2. Output consumed (if_valid && !stall) or output empty (!if_valid):
     - If skid_valid: the skid tuple moves to the output and skid_valid<=0. Any response arriving in the same cycle is impossible, because issue is gated by skid_valid.
     - Else if a response is present: it loads the output, if_valid<=1.
     - Else: if_valid<=0.
  3. Output held (if_valid && stall): if a response is present, it loads the skid and skid_valid<=1. The output is unchanged.
- misaligned defaults to 0 every cycle unless set by a redirect.
- Latency and throughput:
  - An address issued in cycle n appears on if_valid in cycle n+2.
  - Throughput is 1 instruction/cycle with no stall.
  - After a stall releases with the skid full, exactly one bubble issue cycle occurs.
  - No instruction is lost or duplicated.
- First cycle after reset release: issue RESET_PC (if not stalled); the first if_valid comes 2 cycles later.
- Invariant: at most one response is in flight. Skid depth 1 is therefore sufficient and overflow is impossible.

Test Plan:
1. Reset release, memory holds a program whose pc 0x0 word is 0x01400193, no stall -> if_valid rises 2 cycles after release. Deliveries:
   - pc 0x0 -> 0x01400193
   - pc 0x4 -> 0x0781A403
   - pc 0x8 -> 0x00340533
   - continues 1/cycle thereafter.
2. Steady state, stall high 3 cycles while if_pc=0x8 -> if_pc/if_instr held at 0x8 throughout; skid captures pc 0xC. After release the sequence is 0xC then 0x10, one bubble, no duplicates.
3. redirect_valid with target 0x1C, asserted in the cycle if_pc=0x10 is delivered -> pcs 0x14/0x18 never appear with if_valid=1. The next valid output is pc 0x1C -> 0x003476B3, 2 cycles after the redirect.
4. redirect_valid and stall together, with the skid full -> skid and output cleared, fetch resumes at the target once stall drops. Target 0x1E -> fetch 0x1C, misaligned pulses for exactly 1 cycle.
5. Free-run with MEM_BYTES=128 -> last delivered pc 0x7C, fetch_fault=1, no further issues, if_valid drops. A redirect to 0x0 clears the fault and pc 0x0 is redelivered.
6. Assert reset mid-stall with the skid and output full -> all outputs 0 immediately (asynchronous). Restart from RESET_PC is identical to scenario 1.
